// File: rtl/oc8051_cxrom_fetch.sv
// Code fetch buffer: 2-word FIFO streaming bytes from a combinational code ROM.
// Define OC8051_CXROM_FETCH_STATS_EN to add the fetch_cnt word-capture counter.
module oc8051_cxrom_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  input  logic        byte_rd,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [15:0] cxrom_addr,
  input  logic [31:0] cxrom_data_in
`ifdef OC8051_CXROM_FETCH_STATS_EN
  ,
  output logic [15:0] fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL
  } state_t;

  state_t      state, state_nx;
  logic [31:0] d0, d1, d0_nx, d1_nx;
  logic        v0, v1, v0_nx, v1_nx;
  logic [13:0] ptr, ptr_nx;
  logic [1:0]  ofs, ofs_nx;
  logic        rd_ok, pop, wr;

  assign rd_ok      = byte_rd & v0;
  assign pop        = rd_ok & (ofs == 2'd3);
  assign byte_valid = v0;
  assign byte_out   = v0 ? d0[{ofs, 3'b000} +: 8] : 8'h00;
  assign cxrom_addr = {ptr, 2'b00};

  always_comb begin
    state_nx = state;
    d0_nx    = d0;
    d1_nx    = d1;
    v0_nx    = v0;
    v1_nx    = v1;
    ptr_nx   = ptr;
    ofs_nx   = ofs;
    wr       = 1'b0;
    if (pc_load) begin
      v0_nx    = 1'b0;
      v1_nx    = 1'b0;
      ptr_nx   = pc_in[15:2];
      ofs_nx   = pc_in[1:0];
      state_nx = FETCH;
    end else begin
      if (rd_ok) ofs_nx = ofs + 2'd1;
      if (pop) begin
        d0_nx = d1;
        v0_nx = v1;
        v1_nx = 1'b0;
      end
      case (state)
        FETCH: begin
          wr = ~v0 | ~v1 | pop;
          if (!wr) state_nx = FULL;
        end
        FULL:    if (pop) state_nx = FETCH;
        IDLE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
      // The new word lands in the first free slot after any pop shift.
      if (wr) begin
        ptr_nx = ptr + 14'd1;
        if (!v0_nx) begin
          d0_nx = cxrom_data_in;
          v0_nx = 1'b1;
        end else begin
          d1_nx = cxrom_data_in;
          v1_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      d0    <= '0;
      d1    <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
      ptr   <= '0;
      ofs   <= '0;
    end else begin
      state <= state_nx;
      d0    <= d0_nx;
      d1    <= d1_nx;
      v0    <= v0_nx;
      v1    <= v1_nx;
      ptr   <= ptr_nx;
      ofs   <= ofs_nx;
    end
  end

`ifdef OC8051_CXROM_FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
    end else if (wr && fetch_cnt != 16'hFFFF) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Scoreboard bench for oc8051_cxrom_fetch: byte-addressed ROM model,
// expected byte stream queued on each load, monitor pops on each consume.
module tb_oc8051_cxrom_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_load = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic        byte_rd = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;
`ifdef OC8051_CXROM_FETCH_STATS_EN
  logic [15:0] fetch_cnt;
`endif

  int passed = 0;
  int total = 0;
  logic [7:0] expq[$];

  oc8051_cxrom_fetch dut (
    .clk(clk),
    .rst(rst),
    .pc_load(pc_load),
    .pc_in(pc_in),
    .byte_rd(byte_rd),
    .byte_out(byte_out),
    .byte_valid(byte_valid),
    .cxrom_addr(cxrom_addr),
    .cxrom_data_in(cxrom_data_in)
`ifdef OC8051_CXROM_FETCH_STATS_EN
    ,
    .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    logic [31:0] x;
    if (a[15:2] == 14'd0) return 32'h44332211;
    x = {16'h0000, a[15:2], 2'b01};
    return (x * 32'h9E3779B1) ^ {a, ~a};
  endfunction

  function automatic logic [7:0] rom_byte(input logic [15:0] b);
    logic [31:0] w;
    int sh;
    w  = rom_word({b[15:2], 2'b00});
    sh = int'(b[1:0]);
    return w[sh*8 +: 8];
  endfunction

  assign cxrom_data_in = rom_word(cxrom_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (!byte_valid) begin
        chk("byte_out_invalid", 32'(byte_out), 32'h0);
      end else if (byte_rd && !pc_load) begin
        if (expq.size() == 0) chk("queue_empty", 32'd1, 32'd0);
        else chk("byte_stream", 32'(byte_out), 32'(expq.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic rd);
    logic [15:0] b;
    pc_in   = a;
    pc_load = 1'b1;
    byte_rd = rd;
    expq.delete();
    for (int i = 0; i < 48; i++) begin
      b = a + 16'(i);
      expq.push_back(rom_byte(b));
    end
    step();
    pc_load = 1'b0;
    chk("load_flush", 32'(byte_valid), 32'd0);
    chk("load_addr", 32'(cxrom_addr), 32'({a[15:2], 2'b00}));
    step();
    chk("load_latency", 32'(byte_valid), 32'd1);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    expq.delete();
    #1;
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'h0);
    chk("rst_addr", 32'(cxrom_addr), 32'h0);
`ifdef OC8051_CXROM_FETCH_STATS_EN
    chk("rst_cnt", 32'(fetch_cnt), 32'h0);
`endif
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_valid", 32'(byte_valid), 32'd0);
      chk("post_rst_addr", 32'(cxrom_addr), 32'h0);
    end
  endtask

  initial begin
    logic [15:0] a;
    int n;
    #2;
    byte_rd = 1'b1;
    reset_pulse();

    load(16'h0000, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("no_bubble", 32'(byte_valid), 32'd1);
    end

    load(16'h0102, 1'b1);
    for (int i = 0; i < 6; i++) step();

    load(16'h2340, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("full_addr", 32'(cxrom_addr), 32'h2348);
    byte_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_valid", 32'(byte_valid), 32'd1);
    end

    load(16'hFFFC, 1'b1);
    chk("wrap_addr", 32'(cxrom_addr), 32'h0000);
    for (int i = 0; i < 8; i++) step();

    load(16'h1235, 1'b1);
    for (int i = 0; i < 5; i++) step();
    load(16'h4001, 1'b1);
    for (int i = 0; i < 5; i++) step();
    reset_pulse();

    for (int s = 0; s < 25; s++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'hFFF0 | 16'($urandom_range(0, 15));
      load(a, 1'($urandom_range(0, 1)));
      n = $urandom_range(10, 35);
      for (int i = 0; i < n; i++) begin
        byte_rd = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    byte_rd = 1'b0;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
